alarm_resp: RTL and testbench

- Responder to the alarm-match request generated by the clock's alarm comparator.
- Turns the raw "time equals alarm" level into a user-facing ring sequence: ring with timeout, snooze countdown, limited snooze count, and dismiss.
- Clocked by the 1 Hz Pulse, so one clk cycle is one second.
- Its buzz output replaces the plain Alarmon-AND-match gating at the top level.

---
 rtl/alarm_resp_if.sv | 27 ++
 rtl/alarm_resp.sv | 122 ++++++++++++
 tb/tb_alarm_resp.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_resp_if.sv
// Purpose : user-input / buzzer bundle between the alarm responder and its
//           surroundings.
// Signals : match, alarm_on, snooze, dismiss -> responder inputs
//           buzz, snoozing, snz_rem          -> responder outputs
// Modports: master drives the inputs and observes the outputs,
//           slave is the responder side.
interface alarm_resp_if #(
    parameter int unsigned CW = 10
) ();
    logic          match;
    logic          alarm_on;
    logic          snooze;
    logic          dismiss;
    logic          buzz;
    logic          snoozing;
    logic [CW-1:0] snz_rem;

    modport master (
        output match, alarm_on, snooze, dismiss,
        input  buzz, snoozing, snz_rem
    );

    modport slave (
        input  match, alarm_on, snooze, dismiss,
        output buzz, snoozing, snz_rem
    );
endinterface

// File: rtl/alarm_resp.sv
// Purpose : turns the alarm comparator's "time == alarm" level into a ring
//           sequence with ring timeout, snooze countdown, a limited number of
//           snoozes, and dismiss. One clk cycle is one second.
// Ports   : clk  - 1 Hz pulse, rising edge active
//           rst  - asynchronous, active-high reset
//           bus  - alarm_resp_if.slave (match/alarm_on/snooze/dismiss in,
//                  buzz/snoozing/snz_rem out, all outputs registered)
module alarm_resp #(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 540,
    parameter int unsigned MAX_SNZ    = 3,
    parameter int unsigned CW         = 10
) (
    input  logic         clk,
    input  logic         rst,
    alarm_resp_if.slave  bus
);
    localparam int unsigned   UW        = (MAX_SNZ < 1) ? 1 : $clog2(MAX_SNZ + 1);
    localparam logic [CW-1:0] RING_LAST = CW'(RING_SEC - 1);
    localparam logic [CW-1:0] SNZ_LOAD  = CW'(SNOOZE_SEC - 1);
    localparam logic [UW-1:0] SNZ_MAX   = UW'(MAX_SNZ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RING,
        S_SNOOZE,
        S_DONE
    } state_e;

    state_e        state_q,    state_d;
    logic [CW-1:0] ring_ct_q,  ring_ct_d;
    logic [CW-1:0] snz_ct_q,   snz_ct_d;
    logic [UW-1:0] snz_used_q, snz_used_d;
    logic          buzz_q,     buzz_d;
    logic          snoozing_q, snoozing_d;
    logic [CW-1:0] snz_rem_q,  snz_rem_d;

    // State, counters and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ring_ct_q  <= '0;
            snz_ct_q   <= '0;
            snz_used_q <= '0;
            buzz_q     <= 1'b0;
            snoozing_q <= 1'b0;
            snz_rem_q  <= '0;
        end else begin
            state_q    <= state_d;
            ring_ct_q  <= ring_ct_d;
            snz_ct_q   <= snz_ct_d;
            snz_used_q <= snz_used_d;
            buzz_q     <= buzz_d;
            snoozing_q <= snoozing_d;
            snz_rem_q  <= snz_rem_d;
        end
    end

    // Next state, counter updates and output decode
    always_comb begin
        state_d    = state_q;
        ring_ct_d  = ring_ct_q;
        snz_ct_d   = snz_ct_q;
        snz_used_d = snz_used_q;

        case (state_q)
            S_IDLE: begin
                snz_used_d = '0;
                // Level-sensitive: enabling alarm_on mid-minute still rings
                if (bus.match && bus.alarm_on) begin
                    state_d   = S_RING;
                    ring_ct_d = '0;
                end
            end
            S_RING: begin
                if (!bus.alarm_on || bus.dismiss) begin
                    state_d = S_DONE;
                end else if (bus.snooze && (snz_used_q == SNZ_MAX)) begin
                    // Out of snoozes: the press acts as a dismiss
                    state_d = S_DONE;
                end else if (bus.snooze) begin
                    state_d    = S_SNOOZE;
                    snz_ct_d   = SNZ_LOAD;
                    snz_used_d = snz_used_q + UW'(1);
                end else if (ring_ct_q == RING_LAST) begin
                    state_d = S_DONE;
                end else begin
                    ring_ct_d = ring_ct_q + CW'(1);
                end
            end
            S_SNOOZE: begin
                // match is deliberately ignored so ringing resumes after the minute
                if (!bus.alarm_on || bus.dismiss) begin
                    state_d = S_DONE;
                end else if (snz_ct_q == '0) begin
                    state_d   = S_RING;
                    ring_ct_d = '0;
                end else begin
                    snz_ct_d = snz_ct_q - CW'(1);
                end
            end
            S_DONE: begin
                // Hold until the matching minute ends to avoid a retrigger
                if (!bus.match) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        buzz_d     = (state_d == S_RING);
        snoozing_d = (state_d == S_SNOOZE);
        snz_rem_d  = snoozing_d ? snz_ct_d : '0;
    end

    assign bus.buzz     = buzz_q;
    assign bus.snoozing = snoozing_q;
    assign bus.snz_rem  = snz_rem_q;

endmodule

// File: tb/tb_alarm_resp.sv
// Purpose : scoreboard bench for alarm_resp. A stimulus process drives
//           directed scenarios then random traffic, runs a seconds-level
//           reference model and queues the expected outputs; a monitor
//           process pops and compares them every cycle.
module tb_alarm_resp;
    localparam int unsigned RING_SEC   = 5;
    localparam int unsigned SNOOZE_SEC = 3;
    localparam int unsigned MAX_SNZ    = 2;
    localparam int unsigned CW         = 10;

    typedef struct {
        logic buzz;
        logic snoozing;
        int   rem;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    // Reference model: what the alarm is doing and how many seconds are left
    localparam int M_IDLE   = 0;
    localparam int M_RING   = 1;
    localparam int M_SILENT = 2;
    localparam int M_DONE   = 3;
    int mode;
    int ring_left;
    int silence_left;
    int snoozes_taken;

    alarm_resp_if #(.CW(CW)) bus_if ();

    alarm_resp #(
        .RING_SEC  (RING_SEC),
        .SNOOZE_SEC(SNOOZE_SEC),
        .MAX_SNZ   (MAX_SNZ),
        .CW        (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mode          = M_IDLE;
        ring_left     = 0;
        silence_left  = 0;
        snoozes_taken = 0;
    endtask

    // Advance the model by one second with the given button/switch levels
    task automatic model_step(input logic m, input logic a, input logic s, input logic d);
        exp_t e;
        case (mode)
            M_IDLE: begin
                if (m && a) begin
                    mode          = M_RING;
                    ring_left     = RING_SEC;
                    snoozes_taken = 0;
                end
            end
            M_RING: begin
                if (!a || d) begin
                    mode = M_DONE;
                end else if (s) begin
                    if (snoozes_taken >= MAX_SNZ) begin
                        mode = M_DONE;
                    end else begin
                        mode          = M_SILENT;
                        silence_left  = SNOOZE_SEC;
                        snoozes_taken = snoozes_taken + 1;
                    end
                end else begin
                    ring_left = ring_left - 1;
                    if (ring_left == 0) mode = M_DONE;
                end
            end
            M_SILENT: begin
                if (!a || d) begin
                    mode = M_DONE;
                end else begin
                    silence_left = silence_left - 1;
                    if (silence_left == 0) begin
                        mode      = M_RING;
                        ring_left = RING_SEC;
                    end
                end
            end
            default: begin
                if (!m) mode = M_IDLE;
            end
        endcase
        e.buzz     = (mode == M_RING);
        e.snoozing = (mode == M_SILENT);
        e.rem      = (mode == M_SILENT) ? silence_left - 1 : 0;
        exp_q.push_back(e);
    endtask

    // Drive one second of inputs; returns 1 time unit after the edge
    task automatic step(input logic m, input logic a, input logic s, input logic d);
        bus_if.match    = m;
        bus_if.alarm_on = a;
        bus_if.snooze   = s;
        bus_if.dismiss  = d;
        model_step(m, a, s, d);
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n, input logic m, input logic a, input logic s, input logic d);
        for (int i = 0; i < n; i++) step(m, a, s, d);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear without a clock
    task automatic do_reset();
        #4;
        rst = 1'b1;
        #1;
        chk("rst_buzz", 32'(bus_if.buzz), 0);
        chk("rst_snoozing", 32'(bus_if.snoozing), 0);
        chk("rst_snz_rem", 32'(bus_if.snz_rem), 0);
        chk("rst_queue_empty", 32'(exp_q.size()), 0);
        exp_q.delete();
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare every registered output sample against the queue
    always begin
        @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("buzz", 32'(bus_if.buzz), 32'(e.buzz));
            chk("snoozing", 32'(bus_if.snoozing), 32'(e.snoozing));
            chk("snz_rem", 32'(bus_if.snz_rem), 32'(e.rem));
        end
    end

    initial begin
        rst             = 1'b1;
        bus_if.match    = 1'b0;
        bus_if.alarm_on = 1'b0;
        bus_if.snooze   = 1'b0;
        bus_if.dismiss  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Basic ring: five seconds of buzz, hold in DONE, retrigger after gap
        steps(8, 1, 1, 0, 0);
        step(0, 1, 0, 0);
        steps(3, 1, 1, 0, 0);
        step(1, 1, 0, 1);
        step(0, 1, 0, 0);

        // Snooze countdown then a full ring to timeout
        steps(2, 1, 1, 0, 0);
        step(1, 1, 1, 0);
        steps(3, 0, 1, 0, 0);
        steps(6, 0, 1, 0, 0);
        step(0, 1, 0, 0);

        // Snooze limit: two accepted, third ends the event
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        steps(3, 1, 1, 1, 0);
        step(1, 1, 1, 0);
        steps(3, 0, 1, 0, 0);
        step(0, 1, 1, 0);
        steps(2, 0, 1, 0, 0);

        // Priority: dismiss beats snooze; alarm_on low ends a snooze
        step(1, 1, 0, 0);
        step(1, 1, 1, 1);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Async reset mid-ring, then re-ring from IDLE
        steps(3, 1, 1, 0, 0);
        do_reset();
        steps(2, 1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // Late enable within the matching minute
        steps(3, 1, 0, 0, 0);
        steps(2, 1, 1, 0, 0);
        steps(2, 0, 0, 0, 0);

        // Random traffic with sticky match/alarm_on and sparse button presses
        begin
            logic m, a;
            m = 1'b0;
            a = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(19, 0) == 0) m = ~m;
                if ($urandom_range(39, 0) == 0) a = ~a;
                step(m, a, ($urandom_range(7, 0) == 0), ($urandom_range(29, 0) == 0));
                if ($urandom_range(299, 0) == 0) do_reset();
            end
        end

        // Let the monitor drain the last expectations
        repeat (3) @(posedge clk);
        #4;
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
